// File: rtl/loss_layer_ctrl.sv
// loss_layer_ctrl: batch sequencer for the softmax-with-loss datapath.
// Define LOSS_CTRL_LABEL_CHECK_EN to drop samples whose label is out of range and flag label_err.
module loss_layer_ctrl #(
    parameter int WIDTH     = 8,
    parameter int SUB_DELAY = 7,
    parameter int EXP_DELAY = 17,
    parameter int ADD_DELAY = 7,
    parameter int DIV_DELAY = 6,
    parameter int LOG_DELAY = 21
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [15:0]            batch_len,
    output logic                   busy,
    output logic [15:0]            sample_cnt,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0][31:0] in_vec,
    input  logic [31:0]            in_label,
    input  logic [7:0]             in_id,
    output logic                   dp_reset_n,
    output logic [WIDTH-1:0][31:0] dp_all_clsf,
    output logic [31:0]            dp_corr_clsf,
    output logic [7:0]             dp_id,
    output logic                   dp_f_overall_sum,
    input  logic [31:0]            dp_data_out,
    output logic                   loss_valid,
    input  logic                   loss_ready,
`ifdef LOSS_CTRL_LABEL_CHECK_EN
    output logic                   label_err,
`endif
    output logic [31:0]            loss_out
);
    localparam int SUM_CYC = SUB_DELAY + EXP_DELAY + ADD_DELAY * $clog2(WIDTH);
    localparam int FIN_CYC = DIV_DELAY + LOG_DELAY - 1;
    localparam int MAX_A   = SUM_CYC > ADD_DELAY ? SUM_CYC : ADD_DELAY;
    localparam int MAX_CYC = MAX_A > FIN_CYC ? MAX_A : FIN_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {IDLE, CLR, FETCH, SUM_WAIT, ACC_PULSE, ACC_WAIT, FINAL_WAIT, OUT} state_t;

    state_t        state, nxt;
    logic [CW-1:0] dcnt, load;
    logic [15:0]   len_q, cnt_inc;
    logic          hs, bad, done;

    always_comb begin
        hs = state == FETCH && in_valid;
`ifdef LOSS_CTRL_LABEL_CHECK_EN
        bad = in_label >= 32'(WIDTH);
`else
        bad = 1'b0;
`endif
        cnt_inc = sample_cnt == 16'hFFFF ? sample_cnt : sample_cnt + 16'd1;
        done = dcnt == '0;
        nxt = state;
        case (state)
            IDLE:       nxt = start && batch_len != 16'd0 ? CLR : IDLE;
            CLR:        nxt = FETCH;
            // a dropped sample skips the datapath and goes straight to the batch-end decision
            FETCH:      nxt = !hs ? FETCH : !bad ? SUM_WAIT : cnt_inc < len_q ? FETCH : FINAL_WAIT;
            SUM_WAIT:   nxt = done ? ACC_PULSE : SUM_WAIT;
            ACC_PULSE:  nxt = ACC_WAIT;
            ACC_WAIT:   nxt = !done ? ACC_WAIT : sample_cnt < len_q ? FETCH : FINAL_WAIT;
            FINAL_WAIT: nxt = done ? OUT : FINAL_WAIT;
            OUT:        nxt = loss_ready ? IDLE : OUT;
            default:    nxt = IDLE;
        endcase
        load = nxt == SUM_WAIT ? CW'(SUM_CYC - 1) : nxt == ACC_WAIT ? CW'(ADD_DELAY - 1) : CW'(FIN_CYC - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            dcnt             <= '0;
            len_q            <= '0;
            dp_reset_n       <= 1'b0;
            in_ready         <= 1'b0;
            busy             <= 1'b0;
            loss_valid       <= 1'b0;
            dp_f_overall_sum <= 1'b0;
            loss_out         <= '0;
            sample_cnt       <= '0;
            dp_all_clsf      <= '0;
            dp_corr_clsf     <= '0;
            dp_id            <= '0;
`ifdef LOSS_CTRL_LABEL_CHECK_EN
            label_err        <= 1'b0;
`endif
        end else begin
            state            <= nxt;
            dp_reset_n       <= nxt != CLR;
            in_ready         <= nxt == FETCH;
            busy             <= nxt != IDLE;
            dp_f_overall_sum <= nxt == ACC_PULSE;
            loss_valid       <= nxt == OUT;
            dcnt             <= nxt != state ? load : done ? dcnt : dcnt - 1'b1;
            if (state == IDLE && nxt == CLR) begin
                len_q      <= batch_len;
                sample_cnt <= '0;
`ifdef LOSS_CTRL_LABEL_CHECK_EN
                label_err  <= 1'b0;
`endif
            end
            if (hs) sample_cnt <= cnt_inc;
            if (hs && !bad) begin
                dp_all_clsf  <= in_vec;
                dp_corr_clsf <= in_label;
                dp_id        <= in_id;
            end
`ifdef LOSS_CTRL_LABEL_CHECK_EN
            if (hs && bad) label_err <= 1'b1;
`endif
            if (state == FINAL_WAIT && done) loss_out <= dp_data_out;
        end
    end
endmodule

// File: tb/tb_loss_layer_ctrl.sv
// tb_loss_layer_ctrl: table-driven and randomized checks against a cycle-schedule model of loss_layer_ctrl.
module tb_loss_layer_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, loss_ready = 1'b0;
    logic [15:0] batch_len = '0;
    logic [WIDTH-1:0][31:0] in_vec = '0;
    logic [31:0] in_label = '0, dp_data_out = '0;
    logic [7:0] in_id = '0;
    logic busy, in_ready, dp_reset_n, dp_f_overall_sum, loss_valid;
    logic [15:0] sample_cnt;
    logic [WIDTH-1:0][31:0] dp_all_clsf;
    logic [31:0] dp_corr_clsf, loss_out;
    logic [7:0] dp_id;
`ifdef LOSS_CTRL_LABEL_CHECK_EN
    logic label_err;
`endif

    int n_cmp = 0, n_bad = 0, cyc = 0;

    typedef struct {
        int n;
        int rdly;
        int pulses;
        int first_pulse;
        int lv_off;
    } vec_t;
    vec_t tbl[3];

    loss_layer_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .batch_len(batch_len), .busy(busy),
        .sample_cnt(sample_cnt), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .in_label(in_label), .in_id(in_id), .dp_reset_n(dp_reset_n), .dp_all_clsf(dp_all_clsf),
        .dp_corr_clsf(dp_corr_clsf), .dp_id(dp_id), .dp_f_overall_sum(dp_f_overall_sum),
        .dp_data_out(dp_data_out), .loss_valid(loss_valid), .loss_ready(loss_ready),
`ifdef LOSS_CTRL_LABEL_CHECK_EN
        .label_err(label_err),
`endif
        .loss_out(loss_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, a, e);
        end
    endtask

    function automatic logic [31:0] dat(input int c);
        return 32'(c) * 32'h9E3779B1 + 32'h13579BDF;
    endfunction

    function automatic logic [WIDTH-1:0][31:0] rvec();
        logic [WIDTH-1:0][31:0] v;
        for (int i = 0; i < WIDTH; i++) v[i] = $urandom();
        return v;
    endfunction

    // Model: FETCH opens 2 cycles after start; a handshake at cycle h gives the pulse at h+46,
    // the next FETCH at h+54, and for the last sample loss_valid at h+80 carrying dp_data_out of h+79.
    task automatic run_batch(input int n, input int rdly, input bit hold,
                             output int npulse, output int fp, output int lv);
        int f[4], h[4], s, last, e, j, a;
        logic [WIDTH-1:0][31:0] vv[4];
        logic [31:0] lb[4];
        logic [7:0] idv[4];
        logic rdy_e, pls_e;
        s = cyc + 1;
        f[0] = s + 2;
        for (int k = 0; k < n; k++) begin
            h[k] = f[k] + (hold ? 0 : int'($urandom_range(0, 4)));
            f[k+1] = h[k] + 54;
            vv[k] = rvec();
            lb[k] = 32'($urandom_range(0, WIDTH - 1));
            idv[k] = 8'($urandom());
        end
        last = h[n-1];
        e = last + 81 + rdly;
        npulse = 0;
        fp = -1;
        lv = -1;
        for (int c = s; c <= e; c++) begin
            step();
            a = 0;
            rdy_e = 1'b0;
            pls_e = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (h[k] < c) a = k + 1;
                if (f[k] <= c && c <= h[k]) rdy_e = 1'b1;
                if (c == h[k] + 46) pls_e = 1'b1;
            end
            if (c == s) chk("idle_at_start", {busy, in_ready}, 2'b00);
            else chk("ctrl", {busy, in_ready, dp_f_overall_sum, loss_valid, dp_reset_n, sample_cnt},
                     {c <= last + 80 + rdly, rdy_e, pls_e, c >= last + 80 && c <= last + 80 + rdly,
                      c != s + 1, 16'(a)});
            if (a > 0) chk("dp_hold", {dp_all_clsf, dp_corr_clsf, dp_id}, {vv[a-1], lb[a-1], idv[a-1]});
            if (loss_valid) chk("loss_out", loss_out, dat(last + 79));
            if (dp_f_overall_sum) begin
                npulse++;
                if (fp < 0) fp = c - s;
            end
            if (loss_valid && lv < 0) lv = c - s;
            j = -1;
            for (int k = 0; k < n; k++) if (f[k] <= c) j = k;
            in_valid = j >= 0 && c >= h[j];
            in_vec = in_valid ? vv[j] : rvec();
            in_label = in_valid ? lb[j] : $urandom();
            in_id = in_valid ? idv[j] : 8'($urandom());
            start = c == s || (c < last + 81 + rdly && $urandom_range(0, 3) == 0);
            batch_len = c == s ? 16'(n) : 16'($urandom_range(1, 9));
            loss_ready = c == last + 80 + rdly || (c < last + 80 && $urandom_range(0, 1) == 1);
            dp_data_out = dat(c);
        end
        start = 1'b0;
        in_valid = 1'b0;
        loss_ready = 1'b0;
    endtask

    initial begin
        int np, fp, lv;
        tbl[0] = '{1, 0, 1, 48, 82};
        tbl[1] = '{3, 10, 3, 48, 190};
        tbl[2] = '{2, 3, 2, 48, 136};

        repeat (3) step();
        chk("reset_state", {busy, in_ready, dp_reset_n, dp_f_overall_sum, loss_valid, loss_out,
                            sample_cnt, dp_all_clsf, dp_corr_clsf, dp_id}, '0);
`ifdef LOSS_CTRL_LABEL_CHECK_EN
        chk("reset_label_err", label_err, 1'b0);
`endif
        reset = 1'b0;
        step();
        chk("post_reset", {dp_reset_n, busy, in_ready, loss_valid}, 4'b1000);

        for (int i = 0; i < 3; i++) begin
            run_batch(tbl[i].n, tbl[i].rdly, 1'b1, np, fp, lv);
            chk("tbl_pulses", np, tbl[i].pulses);
            chk("tbl_first_pulse", fp, tbl[i].first_pulse);
            chk("tbl_loss_valid_at", lv, tbl[i].lv_off);
        end

        start = 1'b1;
        batch_len = 16'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            start = 1'b0;
            chk("len0_ignored", {busy, dp_reset_n}, 2'b01);
        end

        start = 1'b1;
        batch_len = 16'd3;
        in_valid = 1'b1;
        in_vec = rvec();
        in_label = 32'd2;
        in_id = 8'h55;
        step();
        start = 1'b0;
        repeat (74) step();
        chk("pre_reset_cnt", {busy, sample_cnt}, {1'b1, 16'd2});
        reset = 1'b1;
        step();
        chk("mid_reset", {busy, in_ready, dp_reset_n, dp_f_overall_sum, loss_valid, loss_out,
                          sample_cnt, dp_all_clsf, dp_corr_clsf, dp_id}, '0);
        reset = 1'b0;
        in_valid = 1'b0;
        step();
        run_batch(2, 2, 1'b0, np, fp, lv);
        chk("after_reset_pulses", np, 2);

`ifdef LOSS_CTRL_LABEL_CHECK_EN
        start = 1'b1;
        batch_len = 16'd2;
        in_valid = 1'b1;
        in_vec = rvec();
        in_label = 32'd8;
        in_id = 8'd1;
        step();
        start = 1'b0;
        step();
        step();
        in_label = 32'd3;
        in_id = 8'd2;
        np = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (dp_f_overall_sum) np++;
        end
        chk("lbl_pulses", np, 1);
        chk("lbl_state", {label_err, loss_valid, sample_cnt, dp_corr_clsf, dp_id},
            {1'b1, 1'b1, 16'd2, 32'd3, 8'd2});
        loss_ready = 1'b1;
        step();
        loss_ready = 1'b0;
        in_valid = 1'b0;
        step();
        chk("lbl_done", {busy, loss_valid}, 2'b00);
`endif

        for (int i = 0; i < 6; i++) begin
            int n;
            n = int'($urandom_range(1, 3));
            run_batch(n, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), np, fp, lv);
            chk("rnd_pulses", np, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/loss_layer_ctrl.md
LOSS_LAYER_CTRL -- requirements
Module: loss_layer_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): WIDTH, 8, classes per sample (power of 2, >=2); SUB_DELAY, 7; EXP_DELAY, 17; ADD_DELAY, 7; DIV_DELAY, 6; LOG_DELAY, 21 (all clks of the matching datapath FP unit).
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; reset in 1 synchronous active-high reset.
REQ-003 start in 1 begin batch; batch_len in 16 samples per batch; busy out 1 batch in progress; sample_cnt out 16 samples accepted this batch.
REQ-004 in_valid in 1; in_ready out 1; in_vec in 32xWIDTH classifier scores; in_label in 32 correct class; in_id in 8 sample ID.
REQ-005 dp_reset_n out 1; dp_all_clsf out 32xWIDTH; dp_corr_clsf out 32; dp_id out 8; dp_f_overall_sum out 1; dp_data_out in 32 (all connect to the softmax-with-loss datapath).
REQ-006 loss_out out 32 batch loss; loss_valid out 1; loss_ready in 1; label_err out 1 (present only with the REQ-026 macro).

Function
REQ-007 SHALL implement an FSM with states IDLE, CLR, FETCH, SUM_WAIT, ACC_PULSE, ACC_WAIT, FINAL_WAIT, OUT.
REQ-008 IDLE: start=1 and batch_len!=0 -> CLR, batch_len latched; start with batch_len==0 ignored.
REQ-009 CLR: dp_reset_n=0 for exactly 1 cycle, sample_cnt cleared -> FETCH.
REQ-010 FETCH: in_ready=1; in_valid&in_ready registers in_vec/in_label/in_id onto dp_all_clsf/dp_corr_clsf/dp_id, sample_cnt+1 -> SUM_WAIT.
REQ-011 dp_* data outputs SHALL stay stable from capture until the next FETCH handshake; in_ready=0 in every state except FETCH.
REQ-012 SUM_WAIT SHALL last SUB_DELAY+EXP_DELAY+ADD_DELAY*log2(WIDTH) cycles (45 at defaults), then ACC_PULSE.
REQ-013 ACC_PULSE: dp_f_overall_sum=1 for exactly 1 cycle -> ACC_WAIT; dp_f_overall_sum=0 in all other states.
REQ-014 ACC_WAIT SHALL last ADD_DELAY cycles, then FETCH if sample_cnt<latched batch_len, else FINAL_WAIT.
REQ-015 FINAL_WAIT SHALL last DIV_DELAY+LOG_DELAY-1 cycles (26); loss_out captures dp_data_out on its last cycle -> OUT.
REQ-016 OUT: loss_valid=1, loss_out held until loss_ready=1; the handshake cycle -> IDLE, loss_valid=0 next cycle.
REQ-017 busy=1 in all states except IDLE; start while busy SHALL be ignored.
REQ-018 With in_valid held high, per-sample period SHALL be 1+45+1+7=54 cycles at defaults; in_valid low in FETCH stalls indefinitely with dp_* held.
REQ-019 Delay counter SHALL be sized for the largest wait; no wrap within a state.
REQ-020 sample_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-021 reset SHALL act on the clk edge and override all other inputs, including mid-batch.
REQ-022 Reset values: state IDLE, dp_reset_n 0, in_ready 0, busy 0, loss_valid 0, dp_f_overall_sum 0, loss_out 0, sample_cnt 0, dp_all_clsf/dp_corr_clsf/dp_id 0, label_err 0.
REQ-023 First cycle after reset release in IDLE SHALL drive dp_reset_n=1.
REQ-024 A reset during OUT SHALL discard loss_out without a handshake.

Configuration
REQ-025 Exactly one compile option, the macro LOSS_CTRL_LABEL_CHECK_EN.
REQ-026 Defined: in FETCH a handshake with in_label>=WIDTH SHALL be accepted (sample_cnt+1) but not forwarded; dp_* unchanged, no SUM_WAIT/ACC_PULSE, the FSM goes straight to the REQ-014 decision; label_err sets sticky, cleared in CLR and on reset.
REQ-027 Undefined: label_err port absent; all labels forwarded unchecked.

Verification
REQ-028 batch_len=1, start, handshake at cycle T -> dp_f_overall_sum high only at T+46, loss_valid rises at T+80, loss_out = dp_data_out at T+79.
REQ-029 batch_len=3, in_valid always high -> exactly 3 dp_f_overall_sum pulses 54 cycles apart, sample_cnt=3, one loss_valid.
REQ-030 loss_ready low for 10 cycles in OUT -> loss_valid and loss_out stable 10 cycles; start pulses meanwhile ignored; IDLE after handshake.
REQ-031 reset asserted in SUM_WAIT of sample 2 -> next cycle all outputs at REQ-022 values; new start runs a clean batch.
REQ-032 batch_len=0 with start -> busy stays 0, no dp_reset_n pulse.
REQ-033 Macro defined, batch_len=2, first label=8 -> no pulse for it, label_err=1, one pulse for sample 2; macro undefined -> label forwarded, 2 pulses.
